// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory with configurable access latency and a MEM/WB latch.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int MEM_ADDR_W  = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctlwb_in,
  input  logic [1:0]  ctlm_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rdata2_in,
  input  logic [4:0]  muxout_in,
  output logic        stall,
  output logic [1:0]  ctlwb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  muxout_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err_out
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int         DEPTH  = 2 ** MEM_ADDR_W;
  localparam logic [3:0] LAT_M1 = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [1:0]      ctlwb_q;
  logic [31:0]     read_data_q;
  logic [31:0]     alu_result_q;
  logic [4:0]      muxout_q;
  logic [31:0]     mem_q [DEPTH];

  logic            memread;
  logic            memwrite;
  logic            misaligned;
  logic            access;
  logic            done;
  logic            write_en;
  logic [MEM_ADDR_W-1:0] idx;

  assign memread  = ctlm_in[1];
  assign memwrite = ctlm_in[0];
  assign idx      = alu_result_in[MEM_ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign misaligned       = (memread | memwrite) & (|alu_result_in[1:0]);
  assign misalign_err_out = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  // A trapped access is treated as no access at all: no stall, no write.
  assign access = (memread | memwrite) & ~misaligned;

  always_comb begin
    done = 1'b1;
    if (state_q == IDLE) begin
      done = ~access || (MEM_LATENCY == 0);
    end else begin
      done = (cnt_q == 4'd0);
    end
  end

  // Stall is forced low during reset so an aborted access releases upstream at once.
  assign stall    = ~rst & ~done;
  assign write_en = ~rst & done & access & memwrite;

  // NOTE: the data array has no reset; its contents must survive rst, and a reset
  // loop over every word would also defeat RAM inference.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[idx] <= rdata2_in;
    end
  end

  // NOTE: non-blocking assignments here mean a read in the same edge as a write to the
  // same word sees the old content, which is exactly the read-before-write behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      ctlwb_q      <= 2'b00;
      read_data_q  <= 32'd0;
      alu_result_q <= 32'd0;
      muxout_q     <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (access && (MEM_LATENCY != 0)) begin
            state_q <= BUSY;
            cnt_q   <= LAT_M1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (done) begin
        ctlwb_q      <= misaligned ? 2'b00 : ctlwb_in;
        read_data_q  <= (memread && access) ? mem_q[idx] : 32'd0;
        alu_result_q <= alu_result_in;
        muxout_q     <= muxout_in;
`ifdef MISALIGN_TRAP_EN
        misalign_q   <= misaligned;
`endif
      end else begin
        // Stalled edge: insert a bubble, hold the data fields.
        ctlwb_q      <= 2'b00;
`ifdef MISALIGN_TRAP_EN
        misalign_q   <= 1'b0;
`endif
      end
    end
  end

  assign ctlwb_out      = ctlwb_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign muxout_out     = muxout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances with MEM_LATENCY 0, 2 and 3.
// Define MISALIGN_TRAP_EN when compiling to exercise the misaligned-access trap.
module tb_mem_stage;

  localparam int N = 3;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  mux;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst            [N];
  logic [1:0]  ctlwb_in       [N];
  logic [1:0]  ctlm_in        [N];
  logic [31:0] alu_result_in  [N];
  logic [31:0] rdata2_in      [N];
  logic [4:0]  muxout_in      [N];
  logic        stall          [N];
  logic [1:0]  ctlwb_out      [N];
  logic [31:0] read_data_out  [N];
  logic [31:0] alu_result_out [N];
  logic [4:0]  muxout_out     [N];
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err_out [N];
`endif

  exp_t exp_q [N][$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_stage #(
      .MEM_ADDR_W (8),
      .MEM_LATENCY(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .ctlwb_in      (ctlwb_in[g]),
      .ctlm_in       (ctlm_in[g]),
      .alu_result_in (alu_result_in[g]),
      .rdata2_in     (rdata2_in[g]),
      .muxout_in     (muxout_in[g]),
      .stall         (stall[g]),
      .ctlwb_out     (ctlwb_out[g]),
      .read_data_out (read_data_out[g]),
      .alu_result_out(alu_result_out[g]),
      .muxout_out    (muxout_out[g])
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_err_out(misalign_err_out[g])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: a nonzero ctlwb_out marks a completed access; an edge taken with stall
  // high must have produced a bubble with the data fields held.
  for (genvar m = 0; m < N; m++) begin : g_mon
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rd    = 32'd0;
    logic [31:0] prev_alu   = 32'd0;
    logic [4:0]  prev_mux   = 5'd0;
    always begin
      @(negedge clk);
      if (!rst[m]) begin
        if (prev_stall) begin
          check($sformatf("dut%0d_bubble_ctlwb", m), 32'(ctlwb_out[m]), 32'd0);
          check($sformatf("dut%0d_bubble_rdata", m), read_data_out[m], prev_rd);
          check($sformatf("dut%0d_bubble_alu", m), alu_result_out[m], prev_alu);
          check($sformatf("dut%0d_bubble_mux", m), 32'(muxout_out[m]), 32'(prev_mux));
        end else if (ctlwb_out[m] != 2'b00) begin
          if (exp_q[m].size() == 0) begin
            check($sformatf("dut%0d_spurious_ctlwb", m), 32'(ctlwb_out[m]), 32'd0);
          end else begin
            exp_t e;
            e = exp_q[m].pop_front();
            check($sformatf("dut%0d_ctlwb", m), 32'(ctlwb_out[m]), 32'(e.wb));
            check($sformatf("dut%0d_rdata", m), read_data_out[m], e.rd);
            check($sformatf("dut%0d_alu", m), alu_result_out[m], e.alu);
            check($sformatf("dut%0d_mux", m), 32'(muxout_out[m]), 32'(e.mux));
          end
        end
      end
      #3;
      prev_stall = stall[m];
      prev_rd    = read_data_out[m];
      prev_alu   = alu_result_out[m];
      prev_mux   = muxout_out[m];
    end
  end

  task automatic set_idle(input int d);
    ctlwb_in[d]      = 2'b00;
    ctlm_in[d]       = 2'b00;
    alu_result_in[d] = 32'd0;
    rdata2_in[d]     = 32'd0;
    muxout_in[d]     = 5'd0;
  endtask

  // Present one access, hold it through the stall, push the expected latch contents.
  task automatic issue(input int d, input logic [1:0] wb, input logic [1:0] m,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic [31:0] exp_rd,
                       input int exp_stalls);
    exp_t e;
    int   stalls = 0;
    logic done   = 1'b0;
    @(negedge clk);
    e.wb  = wb;
    e.rd  = exp_rd;
    e.alu = addr;
    e.mux = rd;
    exp_q[d].push_back(e);
    ctlwb_in[d]      = wb;
    ctlm_in[d]       = m;
    alu_result_in[d] = addr;
    rdata2_in[d]     = data;
    muxout_in[d]     = rd;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall[d]) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    check($sformatf("dut%0d_complete_in_budget", d), 32'(done), 32'd1);
    check($sformatf("dut%0d_stall_cycles_addr%0h", d, addr), stalls, exp_stalls);
    @(posedge clk);
    #1;
    set_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1;
      set_idle(d);
    end
    #12;
    for (int d = 0; d < N; d++) begin
      check($sformatf("dut%0d_reset_ctlwb", d), 32'(ctlwb_out[d]), 32'd0);
      check($sformatf("dut%0d_reset_rdata", d), read_data_out[d], 32'd0);
      check($sformatf("dut%0d_reset_alu", d), alu_result_out[d], 32'd0);
      check($sformatf("dut%0d_reset_mux", d), 32'(muxout_out[d]), 32'd0);
    end
    @(negedge clk);
    #4;
    for (int d = 0; d < N; d++) rst[d] = 1'b0;

    // Zero latency: store then load, read-before-write, and address wrap.
    issue(0, 2'b01, 2'b01, 32'h10, 32'hDEADBEEF, 5'd3, 32'd0, 0);
    issue(0, 2'b11, 2'b10, 32'h10, 32'd0, 5'd4, 32'hDEADBEEF, 0);
    issue(0, 2'b01, 2'b01, 32'h20, 32'h1, 5'd5, 32'd0, 0);
    issue(0, 2'b11, 2'b11, 32'h20, 32'h2, 5'd6, 32'h1, 0);
    issue(0, 2'b11, 2'b10, 32'h20, 32'd0, 5'd7, 32'h2, 0);
    issue(0, 2'b01, 2'b01, 32'h000, 32'h0BADBAD0, 5'd8, 32'd0, 0);
    issue(0, 2'b01, 2'b01, 32'h400, 32'hCAFEF00D, 5'd9, 32'd0, 0);
    issue(0, 2'b11, 2'b10, 32'h000, 32'd0, 5'd10, 32'hCAFEF00D, 0);
    issue(0, 2'b10, 2'b10, 32'h410, 32'd0, 5'd11, 32'hDEADBEEF, 0);

    // Two-cycle latency: two bubbles before each completion.
    issue(1, 2'b01, 2'b01, 32'h40, 32'h12345678, 5'd12, 32'd0, 2);
    issue(1, 2'b11, 2'b10, 32'h40, 32'd0, 5'd13, 32'h12345678, 2);

    // Three-cycle latency: reset during the second stall cycle aborts the store.
    issue(2, 2'b01, 2'b01, 32'h30, 32'h11111111, 5'd14, 32'd0, 3);
    @(negedge clk);
    ctlwb_in[2]      = 2'b01;
    ctlm_in[2]       = 2'b01;
    alu_result_in[2] = 32'h30;
    rdata2_in[2]     = 32'h22222222;
    muxout_in[2]     = 5'd15;
    @(negedge clk);
    #1;
    check("dut2_stall_before_abort", 32'(stall[2]), 32'd1);
    #3;
    rst[2] = 1'b1;
    #1;
    check("dut2_abort_stall", 32'(stall[2]), 32'd0);
    check("dut2_abort_ctlwb", 32'(ctlwb_out[2]), 32'd0);
    check("dut2_abort_rdata", read_data_out[2], 32'd0);
    check("dut2_abort_alu", alu_result_out[2], 32'd0);
    check("dut2_abort_mux", 32'(muxout_out[2]), 32'd0);
    set_idle(2);
    @(negedge clk);
    #4;
    rst[2] = 1'b0;
    issue(2, 2'b11, 2'b10, 32'h30, 32'd0, 5'd16, 32'h11111111, 3);

`ifdef MISALIGN_TRAP_EN
    // Misaligned store is trapped: flag for one load, bubble control, memory untouched.
    @(negedge clk);
    ctlwb_in[0]      = 2'b01;
    ctlm_in[0]       = 2'b01;
    alu_result_in[0] = 32'h13;
    rdata2_in[0]     = 32'h55555555;
    muxout_in[0]     = 5'd17;
    #1;
    check("dut0_misalign_stall", 32'(stall[0]), 32'd0);
    @(posedge clk);
    #1;
    check("dut0_misalign_flag", 32'(misalign_err_out[0]), 32'd1);
    check("dut0_misalign_ctlwb", 32'(ctlwb_out[0]), 32'd0);
    check("dut0_misalign_rdata", read_data_out[0], 32'd0);
    set_idle(0);
    @(posedge clk);
    #1;
    check("dut0_misalign_flag_clear", 32'(misalign_err_out[0]), 32'd0);
    issue(0, 2'b11, 2'b10, 32'h10, 32'd0, 5'd18, 32'hDEADBEEF, 0);
`endif

    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("dut%0d_queue_drained", d), exp_q[d].size(), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
